// File: rtl/bus_arbiter.sv
// Two-master (icache/dcache) arbiter onto a single split-transaction system bus.
// Round-robin on ties, forwards response beats combinationally and flags bad burst lengths.
module bus_arbiter #(
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      i_reqcyc,
    input  logic                      i_respack,
    input  logic [BUS_DATA_WIDTH-1:0] i_req,
    input  logic [BUS_TAG_WIDTH-1:0]  i_reqtag,
    output logic                      i_reqack,
    output logic                      i_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] i_resp,
    output logic [BUS_TAG_WIDTH-1:0]  i_resptag,

    input  logic                      d_reqcyc,
    input  logic                      d_respack,
    input  logic [BUS_DATA_WIDTH-1:0] d_req,
    input  logic [BUS_TAG_WIDTH-1:0]  d_reqtag,
    output logic                      d_reqack,
    output logic                      d_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] d_resp,
    output logic [BUS_TAG_WIDTH-1:0]  d_resptag,

    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,

    output logic                      owner,
    output logic                      busy,
    output logic                      protocol_err
);

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    localparam logic [3:0] BeatsCnt = 4'(BEATS);

    state_e                    state_q, state_d;
    logic                      owner_q, owner_d;
    logic                      last_q, last_d;
    logic [BUS_DATA_WIDTH-1:0] req_q, req_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      err_q, err_d;

    logic fwd;
    logic ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            req_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            req_q   <= req_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        req_d   = req_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (i_reqcyc || d_reqcyc) begin
                    // On a tie the master not served last wins.
                    owner_d = (i_reqcyc && d_reqcyc) ? ~last_q : d_reqcyc;
                    req_d   = owner_d ? d_req : i_req;
                    tag_d   = owner_d ? d_reqtag : i_reqtag;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus_reqack) begin
                    cnt_d   = bus_respcyc ? 4'd1 : 4'd0;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus_respcyc) begin
                    if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
                end else if (cnt_q != 4'd0) begin
                    state_d = StIdle;
                    last_d  = owner_q;
                    if (cnt_q != BeatsCnt) err_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        // A beat arriving together with the request ack is already part of the burst.
        ack          = (state_q == StReq) && bus_reqack;
        fwd          = (state_q == StResp) || ack;
        bus_reqcyc   = (state_q == StReq);
        bus_req      = req_q;
        bus_reqtag   = tag_q;
        busy         = (state_q != StIdle);
        owner        = owner_q;
        protocol_err = err_q;
        bus_respack  = fwd && (owner_q ? d_respack : i_respack);
        i_reqack     = ack && !owner_q;
        d_reqack     = ack && owner_q;
        i_respcyc    = fwd && !owner_q && bus_respcyc;
        d_respcyc    = fwd && owner_q && bus_respcyc;
        i_resp       = (fwd && !owner_q) ? bus_resp : '0;
        i_resptag    = (fwd && !owner_q) ? bus_resptag : '0;
        d_resp       = (fwd && owner_q) ? bus_resp : '0;
        d_resptag    = (fwd && owner_q) ? bus_resptag : '0;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: scenario tasks with randomized data checked
// against a transaction-level model of grant order and burst-length errors.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_reqcyc = 0, i_respack = 0, d_reqcyc = 0, d_respack = 0;
    logic [63:0] i_req = '0, d_req = '0;
    logic [12:0] i_reqtag = '0, d_reqtag = '0;
    logic        i_reqack, i_respcyc, d_reqack, d_respcyc;
    logic [63:0] i_resp, d_resp;
    logic [12:0] i_resptag, d_resptag;
    logic        bus_reqcyc, bus_respack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack = 0, bus_respcyc = 0;
    logic [63:0] bus_resp = '0;
    logic [12:0] bus_resptag = '0;
    logic        owner, busy, protocol_err;

    int tests = 0;
    int fails = 0;

    // Transaction-level model: who was served last, and whether a bad burst was seen.
    bit exp_last = 1'b0;
    bit exp_err  = 1'b0;

    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .i_reqcyc(i_reqcyc), .i_respack(i_respack), .i_req(i_req), .i_reqtag(i_reqtag),
        .i_reqack(i_reqack), .i_respcyc(i_respcyc), .i_resp(i_resp), .i_resptag(i_resptag),
        .d_reqcyc(d_reqcyc), .d_respack(d_respack), .d_req(d_req), .d_reqtag(d_reqtag),
        .d_reqack(d_reqack), .d_respcyc(d_respcyc), .d_resp(d_resp), .d_resptag(d_resptag),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack), .bus_req(bus_req),
        .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .owner(owner), .busy(busy), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; reset_after>0 aborts with a reset once that many beats arrived.
    task automatic run_txn(input int mask, input int nbeats, input bit ack_beat,
                           input int ack_delay, input int reset_after);
        logic [63:0] ia, da, ea, rd;
        logic [12:0] it, dt, et, rt;
        bit own, ir, dr, eack;
        int got;
        ia = {$urandom, $urandom};
        da = {$urandom, $urandom};
        it = 13'($urandom);
        dt = 13'($urandom);
        own = (mask == 3) ? ~exp_last : (mask == 2);
        ea = own ? da : ia;
        et = own ? dt : it;
        i_reqcyc = (mask & 1) != 0;
        d_reqcyc = (mask & 2) != 0;
        i_req = ia; i_reqtag = it; d_req = da; d_reqtag = dt;
        bus_reqack = 0; bus_respcyc = 0;
        #2;
        tests++;
        if (busy !== 1'b0 || bus_reqcyc !== 1'b0) begin
            fails++;
            $display("FAIL idle_state: busy=%b bus_reqcyc=%b required 0 0", busy, bus_reqcyc);
        end
        tests++;
        if ({i_respcyc, d_respcyc, bus_respack} !== 3'b000) begin
            fails++;
            $display("FAIL idle_resp: i/d_respcyc,bus_respack=%b required 000",
                     {i_respcyc, d_respcyc, bus_respack});
        end
        cyc();
        if (own) d_reqcyc = 0; else i_reqcyc = 0;
        for (int k = 0; k <= ack_delay; k++) begin
            bus_reqack = (k == ack_delay);
            bus_respcyc = bus_reqack && ack_beat;
            rd = {$urandom, $urandom};
            rt = 13'($urandom);
            bus_resp = rd; bus_resptag = rt;
            #2;
            tests++;
            if (bus_reqcyc !== 1'b1 || bus_req !== ea || bus_reqtag !== et) begin
                fails++;
                $display("FAIL req_hold: reqcyc=%b req=%h tag=%h required 1 %h %h",
                         bus_reqcyc, bus_req, bus_reqtag, ea, et);
            end
            tests++;
            if (owner !== own || busy !== 1'b1) begin
                fails++;
                $display("FAIL grant: owner=%b busy=%b required %b 1", owner, busy, own);
            end
            tests++;
            if ((own ? d_reqack : i_reqack) !== bus_reqack || (own ? i_reqack : d_reqack) !== 1'b0)
            begin
                fails++;
                $display("FAIL reqack: i=%b d=%b required owner=%b", i_reqack, d_reqack,
                         bus_reqack);
            end
            if (bus_respcyc) begin
                tests++;
                if ((own ? d_respcyc : i_respcyc) !== 1'b1 || (own ? d_resp : i_resp) !== rd) begin
                    fails++;
                    $display("FAIL ack_beat: respcyc i=%b d=%b resp=%h required %h",
                             i_respcyc, d_respcyc, own ? d_resp : i_resp, rd);
                end
            end
            cyc();
        end
        bus_reqack = 0;
        got = ack_beat ? 1 : 0;
        if (!ack_beat) begin
            bus_respcyc = 0;
            #2;
            tests++;
            if (busy !== 1'b1) begin
                fails++;
                $display("FAIL resp_wait: busy=%b required 1", busy);
            end
            cyc();
        end
        while (got < nbeats) begin
            bus_respcyc = 1;
            rd = {$urandom, $urandom};
            rt = 13'($urandom);
            bus_resp = rd; bus_resptag = rt;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            i_respack = ir; d_respack = dr;
            eack = own ? dr : ir;
            if (reset_after != 0 && got == reset_after) begin
                reset = 1; i_reqcyc = 1; d_reqcyc = 1;
                cyc();
                #2;
                tests++;
                if (busy !== 1'b0 || bus_reqcyc !== 1'b0 || bus_req !== 64'h0) begin
                    fails++;
                    $display("FAIL mid_reset_state: busy=%b reqcyc=%b req=%h required 0 0 0",
                             busy, bus_reqcyc, bus_req);
                end
                tests++;
                if ({i_respcyc, d_respcyc, bus_respack, protocol_err} !== 4'b0000) begin
                    fails++;
                    $display("FAIL mid_reset_resp: i,d_respcyc,respack,err=%b required 0000",
                             {i_respcyc, d_respcyc, bus_respack, protocol_err});
                end
                reset = 0; i_reqcyc = 0; d_reqcyc = 0; bus_respcyc = 0;
                exp_last = 1'b0;
                exp_err = 1'b0;
                return;
            end
            #2;
            tests++;
            if ((own ? d_respcyc : i_respcyc) !== 1'b1 || (own ? d_resp : i_resp) !== rd ||
                (own ? d_resptag : i_resptag) !== rt) begin
                fails++;
                $display("FAIL beat_fwd: beat %0d resp=%h tag=%h required %h %h", got,
                         own ? d_resp : i_resp, own ? d_resptag : i_resptag, rd, rt);
            end
            tests++;
            if (bus_respack !== eack) begin
                fails++;
                $display("FAIL respack: got %b required %b", bus_respack, eack);
            end
            tests++;
            if ((own ? i_respcyc : d_respcyc) !== 1'b0 || (own ? i_resp : d_resp) !== 64'h0 ||
                (own ? i_resptag : d_resptag) !== 13'h0) begin
                fails++;
                $display("FAIL non_owner: respcyc i=%b d=%b required owner only", i_respcyc,
                         d_respcyc);
            end
            got++;
            cyc();
        end
        bus_respcyc = 0; i_respack = 0; d_respack = 0;
        #2;
        tests++;
        if (busy !== 1'b1 || (own ? d_respcyc : i_respcyc) !== 1'b0) begin
            fails++;
            $display("FAIL burst_end: busy=%b respcyc i=%b d=%b required 1 0", busy, i_respcyc,
                     d_respcyc);
        end
        cyc();
        exp_last = own;
        if (nbeats != 8) exp_err = 1'b1;
        #2;
        tests++;
        if (busy !== 1'b0 || bus_reqcyc !== 1'b0) begin
            fails++;
            $display("FAIL return_idle: busy=%b reqcyc=%b required 0 0", busy, bus_reqcyc);
        end
        tests++;
        if (protocol_err !== exp_err) begin
            fails++;
            $display("FAIL protocol_err: got %b required %b (beats %0d)", protocol_err, exp_err,
                     nbeats);
        end
        i_reqcyc = 0; d_reqcyc = 0;
    endtask

    task automatic test_reset();
        reset = 1; i_reqcyc = 1; d_reqcyc = 1; bus_reqack = 1; bus_respcyc = 1;
        cyc();
        cyc();
        #2;
        tests++;
        if ({busy, bus_reqcyc, protocol_err} !== 3'b000 || bus_req !== 64'h0 ||
            bus_reqtag !== 13'h0) begin
            fails++;
            $display("FAIL reset_state: busy,reqcyc,err=%b req=%h tag=%h required 000 0 0",
                     {busy, bus_reqcyc, protocol_err}, bus_req, bus_reqtag);
        end
        tests++;
        if ({i_respcyc, d_respcyc, bus_respack, i_reqack, d_reqack} !== 5'b00000) begin
            fails++;
            $display("FAIL reset_outputs: got %b required 00000",
                     {i_respcyc, d_respcyc, bus_respack, i_reqack, d_reqack});
        end
        reset = 0; i_reqcyc = 0; d_reqcyc = 0; bus_reqack = 0; bus_respcyc = 0;
        exp_last = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic test_icache_only();
        run_txn(1, 8, 1'b0, 0, 0);
    endtask

    task automatic test_tie_round_robin();
        run_txn(3, 8, 1'b0, 0, 0);  // dcache wins first tie after reset
        run_txn(1, 8, 1'b0, 1, 0);  // icache follows after one idle cycle
        run_txn(3, 8, 1'b0, 0, 0);
        run_txn(3, 8, 1'b1, 0, 0);
    endtask

    task automatic test_drop_early();
        run_txn(2, 8, 1'b0, 3, 0);
    endtask

    task automatic test_same_cycle();
        run_txn(2, 8, 1'b1, 0, 0);
        run_txn(1, 8, 1'b1, 2, 0);
    endtask

    task automatic test_short_burst();
        run_txn(2, 5, 1'b0, 0, 0);
        run_txn(1, 8, 1'b0, 0, 0);  // error must stay sticky
    endtask

    task automatic test_saturate();
        run_txn(1, 16, 1'b0, 0, 0);
    endtask

    task automatic test_mid_reset();
        run_txn(2, 8, 1'b0, 0, 3);
        run_txn(1, 8, 1'b0, 0, 0);
        run_txn(3, 8, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_txn(int'($urandom_range(1, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 8,
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0);
        end
    endtask

    initial begin
        test_reset();
        test_icache_only();
        test_tie_round_robin();
        test_drop_early();
        test_same_cycle();
        test_short_burst();
        test_saturate();
        test_mid_reset();
        test_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BUS_TAG_WIDTH, default 13, SHALL set the width of all tag ports.
REQ-002 Parameter BUS_DATA_WIDTH, default 64, SHALL set the width of all request and response data ports.
REQ-003 Parameter BEATS, default 8, SHALL give the expected response beats per transaction (one 512-bit line).
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 i_reqcyc, i_respack  in  1  icache request valid and response acknowledge.
REQ-007 i_req  in  BUS_DATA_WIDTH, i_reqtag  in  BUS_TAG_WIDTH  icache request address and tag.
REQ-008 i_reqack, i_respcyc  out  1  icache request accepted and response beat valid.
REQ-009 i_resp  out  BUS_DATA_WIDTH, i_resptag  out  BUS_TAG_WIDTH  icache response data and tag.
REQ-010 d_* ports SHALL be identical to the i_* ports (REQ-006..009) and serve the dcache.
REQ-011 bus_reqcyc, bus_respack  out  1; bus_req  out  BUS_DATA_WIDTH; bus_reqtag  out  BUS_TAG_WIDTH  system-bus request side.
REQ-012 bus_reqack, bus_respcyc  in  1; bus_resp  in  BUS_DATA_WIDTH; bus_resptag  in  BUS_TAG_WIDTH  system-bus response side.
REQ-013 owner  out  1  current grant (0=icache, 1=dcache); valid when busy=1.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 protocol_err  out  1  sticky flag for a beat-count mismatch.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, REQ, RESP.
REQ-017 IDLE, one requester high: at the clock edge, grant that requester, latch its req/reqtag into bus_req/bus_reqtag, set bus_reqcyc=1, go to REQ.
REQ-018 IDLE, both requesters high: grant the requester not served last (round-robin); after reset the dcache wins the first tie.
REQ-019 bus_reqcyc SHALL rise exactly 1 cycle after the cycle in which the owner's reqcyc was sampled high in IDLE.
REQ-020 REQ: hold bus_reqcyc=1 with bus_req/bus_reqtag stable until bus_reqack=1, even if the owner drops reqcyc.
REQ-021 REQ with bus_reqack=1: the owner's reqack SHALL equal bus_reqack combinationally that cycle; at the edge, bus_reqcyc<=0, beat counter<=0, state<=RESP.
REQ-022 REQ with bus_reqack=1 and bus_respcyc=1 in the same cycle: that beat SHALL be forwarded and counted as beat 1.
REQ-023 RESP: owner respcyc = bus_respcyc; owner resp/resptag = bus_resp/bus_resptag; bus_respack = owner respack; all combinational with no added latency.
REQ-024 The non-owner SHALL see reqack=0 and respcyc=0 at all times; its resp/resptag SHALL be 0.
REQ-025 In IDLE, bus_respack SHALL be 0 and both i_respcyc and d_respcyc SHALL be 0.
REQ-026 RESP: the 4-bit beat counter SHALL increment on each cycle with bus_respcyc=1 and SHALL saturate at 15.
REQ-027 RESP with bus_respcyc=0 and counter>0: go to IDLE and record the owner as last-served.
REQ-028 Also on that RESP-to-IDLE transition: if counter != BEATS, set protocol_err<=1.
REQ-029 RESP with bus_respcyc=0 and counter=0: remain in RESP (bus still waiting).
REQ-030 A request from the non-owner during REQ or RESP SHALL wait; it is arbitrated in the first IDLE cycle after return.
REQ-031 Back-to-back transactions SHALL cost exactly 1 IDLE cycle between the last beat and the next bus_reqcyc rise.

Reset
REQ-032 reset=1 SHALL, at the next edge, force state=IDLE, bus_reqcyc=0, bus_req=0, bus_reqtag=0, counter=0, protocol_err=0, and last-served=icache.
REQ-033 reset asserted mid-transaction SHALL abandon the transaction; owner respcyc and bus_respack SHALL be 0 from the following cycle.
REQ-034 reset SHALL take precedence over every simultaneous request or bus event.

Verification
REQ-035 icache only: i_reqcyc=1, i_req=0x1000 -> bus_reqcyc=1 and bus_req=0x1000 next cycle; on bus_reqack, i_reqack pulses; 8 beats reach i_resp; d_respcyc stays 0; protocol_err=0.
REQ-036 Tie after reset: both request (i_req=0x40, d_req=0x80) -> bus_req=0x80 first; after its 8 beats plus 1 idle cycle, bus_req=0x40.
REQ-037 Requester drops early: d_reqcyc falls in REQ before bus_reqack -> bus_reqcyc held at 1 until bus_reqack; transaction completes normally.
REQ-038 Short burst: bus delivers 5 beats then drops bus_respcyc -> return to IDLE, protocol_err=1 and held until reset.
REQ-039 Same-cycle ack and beat: bus_reqack=1 and bus_respcyc=1 together -> beat forwarded and counted; 7 further beats complete with protocol_err=0.
REQ-040 Mid-burst reset: reset after beat 3 -> next cycle busy=0, bus_reqcyc=0, d_respcyc=0; a fresh request then proceeds per REQ-017.
